vga_sync_gen: RTL and testbench

- Video timing generator for the parallax user project. Drives the HSYNC, VSYNC and RGB pads (io_out[8], io_out[9], io_out[12:10]) that the chip-level VGA bench monitors.
- Produces pixel coordinates for the upstream renderer and accepts its 3-bit colour one pixel later.
- Aligns colour, blanking and sync, then registers all pad outputs.

---
 rtl/vga_sync_gen.sv | 174 +++++++++++++++++
 tb/tb_vga_sync_gen.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA video timing generator for the parallax user project.
//
// Issues pixel coordinates (x, y) to the renderer, accepts the renderer colour
// one pix_ce later, and drives the registered HSYNC/VSYNC/RGB pad outputs.
// Colour, blanking and sync all pass through the same two pix_ce stages, so the
// pads for position (x, y) appear two pix_ce strobes after (x, y) is issued.
//
// Optional build macro: VGA_TEST_PATTERN_EN
//   When defined, pattern_sel=1 replaces rgb_in with eight 80-pixel colour bars.
//   When undefined, no pattern logic exists and pattern_sel is ignored.
//
// Ports:
//   wb_clk_i     in   system clock
//   wb_rst_i     in   synchronous active-high reset
//   pix_ce       in   pixel clock-enable; all state advances only when high
//   rgb_in[2:0]  in   renderer colour for coordinates issued on the previous pix_ce
//   pattern_sel  in   select internal test pattern (VGA_TEST_PATTERN_EN builds only)
//   x[9:0]       out  horizontal counter
//   y[9:0]       out  vertical counter
//   line_start   out  one wb_clk_i pulse on the pix_ce where x==0
//   frame_start  out  one wb_clk_i pulse on the pix_ce where x==0 and y==0
//   hsync        out  registered HSYNC pad
//   vsync        out  registered VSYNC pad
//   rgb[2:0]     out  registered colour pad, 0 during blanking

module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 24,
    parameter int unsigned H_SYNC    = 40,
    parameter int unsigned H_BACK    = 128,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 9,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 28,
    parameter bit          SYNC_NEG  = 1'b1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       pix_ce,
    input  logic [2:0] rgb_in,
    input  logic       pattern_sel,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counters are 10 bits wide; larger timings cannot be represented.
    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_timing
        $error("vga_sync_gen: line or frame total exceeds 10-bit counter range");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       vis_q, vis_d, hs_q, hs_d, vs_q, vs_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic [2:0] rgb_q, rgb_d;
    logic [2:0] colour;
    logic       h_act, v_act, hs_on, vs_on;

    // Decode of the current counters.
    always_comb begin
        h_act = (x_q < H_VIS);
        v_act = (y_q < V_VIS);
        hs_on = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
        // y only: VSYNC edges line up with x==0 of the line.
        vs_on = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar, bar_q;
    logic       sel_q;

    // Bar index is x/80, built from threshold compares instead of a divider.
    always_comb begin
        bar = 3'd0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (x_q >= 10'(i * 80)) begin
                bar = 3'(i);
            end
        end
    end

    // Bar colour and select travel with stage 1 so they line up with vis_q.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bar_q <= 3'd0;
            sel_q <= 1'b0;
        end else if (pix_ce) begin
            bar_q <= bar;
            sel_q <= pattern_sel;
        end
    end

    assign colour = sel_q ? bar_q : rgb_in;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign colour             = rgb_in;
`endif

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        vis_d   = vis_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (pix_ce) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
            // Stage 1: decode of the coordinates being issued now.
            vis_d   = h_act & v_act;
            hs_d    = hs_on;
            vs_d    = vs_on;
            // Stage 2: pads; rgb_in now carries the colour for the stage-1 position.
            hsync_d = hs_q ^ SYNC_NEG;
            vsync_d = vs_q ^ SYNC_NEG;
            rgb_d   = vis_q ? colour : 3'b000;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            vis_q   <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hsync_q <= SYNC_NEG;
            vsync_q <= SYNC_NEG;
            rgb_q   <= 3'b000;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            vis_q   <= vis_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    // Held low during reset so no spurious start pulse is seen.
    assign line_start  = pix_ce & ~wb_rst_i & (x_q == 10'd0);
    assign frame_start = pix_ce & ~wb_rst_i & (x_q == 10'd0) & (y_q == 10'd0);

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
// Testbench for vga_sync_gen. Horizontal timing uses the default 832-pixel
// line; the frame is shortened to 15 lines (8 visible, 2 front, 3 sync, 2 back)
// so whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int HT    = 832;
    localparam int VV    = 8;
    localparam int VF    = 2;
    localparam int VS    = 3;
    localparam int VB    = 2;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       sel;
    logic [2:0] rgb_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;

    int checks;
    int errors;
    int n;  // pix_ce strobes since reset release

    vga_sync_gen #(
        .V_VISIBLE(VV),
        .V_FRONT  (VF),
        .V_SYNC   (VS),
        .V_BACK   (VB)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pix_ce     (ce),
        .rgb_in     (rgb_in),
        .pattern_sel(sel),
        .x          (x),
        .y          (y),
        .line_start (ls),
        .frame_start(fs),
        .hsync      (hs),
        .vsync      (vs),
        .rgb        (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        logic c;
        logic r;
        c = ce;
        r = rst;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else if (c) n++;
    endtask

    // Pad after strobe k shows position k-2; before that, the cleared pipeline.
    function automatic logic exp_hs(input int k);
        int px;
        if (k < 2) return 1'b1;
        px = (k - 2) % HT;
        return !(px >= 664 && px <= 703);
    endfunction

    function automatic logic exp_vs(input int k);
        int py;
        if (k < 2) return 1'b1;
        py = ((k - 2) / HT) % VT;
        return !(py >= VV + VF && py <= VV + VF + VS - 1);
    endfunction

    function automatic logic exp_vis(input int k);
        int px;
        int py;
        if (k < 2) return 1'b0;
        px = (k - 2) % HT;
        py = ((k - 2) / HT) % VT;
        return (px < 640) && (py < VV);
    endfunction

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; sel = 1'b0; rgb_in = 3'b101;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({hs, vs, rgb} !== 5'b11_000) begin
                errors++;
                $display("FAIL reset_pads: got hs,vs,rgb=%b want 11000", {hs, vs, rgb});
            end
            checks++;
            if ({x, y} !== 20'd0) begin
                errors++;
                $display("FAIL reset_counters: got x=%0d y=%0d want 0 0", x, y);
            end
            checks++;
            if ({ls, fs} !== 2'b00) begin
                errors++;
                $display("FAIL reset_starts: got ls,fs=%b want 00", {ls, fs});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_hsync_timing();
        int   fall1, fall2, rise1, ls_bad;
        logic prev;
        fall1 = -1; fall2 = -1; rise1 = -1; ls_bad = 0;
        prev = hs;
        for (int k = 0; k < 1600; k++) begin
            #1;
            if (ls !== (n % HT == 0)) ls_bad++;
            step();
            if (prev && !hs) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!prev && hs && fall1 >= 0 && rise1 < 0) rise1 = n;
            prev = hs;
        end
        checks++;
        if (fall1 != 666) begin
            errors++; $display("FAIL hsync_first_fall: got %0d want 666", fall1);
        end
        checks++;
        if (rise1 - fall1 != 40) begin
            errors++; $display("FAIL hsync_width: got %0d want 40", rise1 - fall1);
        end
        checks++;
        if (fall2 - fall1 != HT) begin
            errors++; $display("FAIL hsync_period: got %0d want %0d", fall2 - fall1, HT);
        end
        checks++;
        if (ls_bad != 0) begin
            errors++; $display("FAIL line_start_trace: got %0d bad cycles want 0", ls_bad);
        end
    endtask

    task automatic test_frames();
        int         bad, first_bad, fs_bad, fs_cnt, vf1, vf2, vr1, vis0, vis8;
        logic       prevv, hs_at_fall;
        logic [2:0] er;
        bad = 0; first_bad = -1; fs_bad = 0; fs_cnt = 0;
        vf1 = -1; vf2 = -1; vr1 = -1; vis0 = 0; vis8 = 0; hs_at_fall = 1'b0;
        rgb_in = 3'b101;
        prevv = vs;
        while (n < 23500) begin
            #1;
            if (fs !== (n % FRAME == 0)) fs_bad++;
            if (fs === 1'b1) fs_cnt++;
            step();
            er = exp_vis(n) ? 3'b101 : 3'b000;
            if (hs !== exp_hs(n) || vs !== exp_vs(n) || rgb !== er ||
                x !== 10'(n % HT) || y !== 10'((n / HT) % VT)) begin
                bad++;
                if (first_bad < 0) first_bad = n;
            end
            if (prevv && !vs) begin
                if (vf1 < 0) begin
                    vf1 = n; hs_at_fall = hs;
                end else if (vf2 < 0) begin
                    vf2 = n;
                end
            end
            if (!prevv && vs && vf1 >= 0 && vr1 < 0) vr1 = n;
            prevv = vs;
            if (n >= FRAME + 2 && n < FRAME + 2 + HT && rgb === 3'b101) vis0++;
            if (n >= FRAME + 2 + VV * HT && n < FRAME + 2 + (VV + 1) * HT && rgb !== 3'b000)
                vis8++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_trace: got %0d bad cycles (first at strobe %0d) want 0",
                     bad, first_bad);
        end
        checks++;
        if (fs_bad != 0) begin
            errors++; $display("FAIL frame_start_trace: got %0d bad cycles want 0", fs_bad);
        end
        checks++;
        if (fs_cnt != 1) begin
            errors++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
        end
        checks++;
        if (vf1 != 8322) begin
            errors++; $display("FAIL vsync_first_fall: got %0d want 8322", vf1);
        end
        checks++;
        if (vf2 - vf1 != FRAME) begin
            errors++; $display("FAIL vsync_period: got %0d want %0d", vf2 - vf1, FRAME);
        end
        checks++;
        if (vr1 - vf1 != 3 * HT) begin
            errors++; $display("FAIL vsync_width: got %0d want %0d", vr1 - vf1, 3 * HT);
        end
        checks++;
        if (hs_at_fall !== 1'b1) begin
            errors++; $display("FAIL hsync_at_vsync_fall: got %b want 1", hs_at_fall);
        end
        checks++;
        if (vis0 != 640) begin
            errors++; $display("FAIL rgb_line0_count: got %0d want 640", vis0);
        end
        checks++;
        if (vis8 != 0) begin
            errors++; $display("FAIL rgb_blank_line: got %0d nonzero cycles want 0", vis8);
        end
    endtask

    task automatic test_rst_mid_line();
        int   guard, fall, rise;
        logic prev;
        guard = 0;
        while (x !== 10'd680 && guard < 2000) begin
            step();
            guard++;
        end
        checks++;
        if (x !== 10'd680) begin
            errors++; $display("FAIL reach_x680: got x=%0d want 680", x);
        end
        checks++;
        if (hs !== 1'b0) begin
            errors++; $display("FAIL mid_hsync_low: got %b want 0", hs);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({hs, vs, rgb} !== 5'b11_000) begin
            errors++; $display("FAIL mid_reset_pads: got hs,vs,rgb=%b want 11000", {hs, vs, rgb});
        end
        checks++;
        if ({x, y} !== 20'd0) begin
            errors++; $display("FAIL mid_reset_counters: got x=%0d y=%0d want 0 0", x, y);
        end
        fall = -1; rise = -1;
        prev = hs;
        for (int k = 0; k < 800; k++) begin
            step();
            if (prev && !hs && fall < 0) fall = n;
            if (!prev && hs && fall >= 0 && rise < 0) rise = n;
            prev = hs;
        end
        checks++;
        if (fall != 666) begin
            errors++; $display("FAIL resume_hsync_fall: got %0d want 666", fall);
        end
        checks++;
        if (rise - fall != 40) begin
            errors++; $display("FAIL resume_hsync_width: got %0d want 40", rise - fall);
        end
    endtask

    task automatic test_ce_quarter();
        int          fall, fall2, rise, hold_bad, ls_cnt, ls_bad;
        logic        prev, prev_ls;
        logic [24:0] snap;
        rst = 1'b1; ce = 1'b1;
        step();
        rst = 1'b0;
        fall = -1; fall2 = -1; rise = -1; hold_bad = 0; ls_cnt = 0; ls_bad = 0;
        prev = hs; prev_ls = 1'b0;
        for (int c = 1; c <= 6100; c++) begin
            ce = ((c - 1) % 4 == 0);
            #1;
            if (ls !== (ce && (n % HT == 0))) ls_bad++;
            if (ls === 1'b1) begin
                ls_cnt++;
                if (prev_ls) ls_bad++;
            end
            prev_ls = ls;
            snap = {hs, vs, rgb, x, y};
            step();
            if (!ce && {hs, vs, rgb, x, y} !== snap) hold_bad++;
            if (prev && !hs) begin
                if (fall < 0) fall = c;
                else if (fall2 < 0) fall2 = c;
            end
            if (!prev && hs && fall >= 0 && rise < 0) rise = c;
            prev = hs;
        end
        ce = 1'b1;
        checks++;
        if (fall != 2661) begin
            errors++; $display("FAIL quarter_hsync_fall: got %0d want 2661", fall);
        end
        checks++;
        if (rise - fall != 160) begin
            errors++; $display("FAIL quarter_hsync_width: got %0d want 160", rise - fall);
        end
        checks++;
        if (fall2 - fall != 4 * HT) begin
            errors++; $display("FAIL quarter_hsync_period: got %0d want %0d", fall2 - fall, 4 * HT);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++; $display("FAIL quarter_hold: got %0d changed cycles want 0", hold_bad);
        end
        checks++;
        if (ls_cnt != 2) begin
            errors++; $display("FAIL quarter_line_start_count: got %0d want 2", ls_cnt);
        end
        checks++;
        if (ls_bad != 0) begin
            errors++; $display("FAIL quarter_line_start_width: got %0d bad cycles want 0", ls_bad);
        end
    endtask

    // Renderer returns colour (position mod 8) one strobe after each coordinate.
    task automatic test_rgb_align();
        int         bad;
        logic [2:0] er;
        rst = 1'b1; ce = 1'b1; sel = 1'b0;
        step();
        rst = 1'b0;
        rgb_in = 3'd7;
        bad = 0;
        for (int k = 0; k < 700; k++) begin
            step();
            er = (n >= 2 && (n - 2) < 640) ? 3'((n - 2) % 8) : 3'b000;
            if (rgb !== er) bad++;
            rgb_in = 3'((n + 7) % 8);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rgb_alignment: got %0d bad cycles want 0", bad);
        end
        rgb_in = 3'b101;
    endtask

    task automatic test_pattern();
        int         bad;
        logic [2:0] er;
`ifdef VGA_TEST_PATTERN_EN
        rst = 1'b1; ce = 1'b1; sel = 1'b1; rgb_in = 3'b010;
        step();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 840; k++) begin
            step();
            er = (n >= 2 && (n - 2) < 640) ? 3'((n - 2) / 80) : 3'b000;
            if (rgb !== er) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pattern_bars: got %0d bad cycles want 0", bad);
        end
        sel = 1'b0;
`else
        sel = 1'b1;  // no pattern in this build: select must be ignored
`endif
        rst = 1'b1; ce = 1'b1; rgb_in = 3'b110;
        step();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 700; k++) begin
            step();
            er = (n >= 2 && (n - 2) < 640) ? 3'b110 : 3'b000;
            if (rgb !== er) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pattern_passthrough: got %0d bad cycles want 0", bad);
        end
        sel = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; n = 0;
        rst = 1'b1; ce = 1'b0; sel = 1'b0; rgb_in = 3'b000;
        test_reset();
        test_hsync_timing();
        test_frames();
        test_rst_mid_line();
        test_ce_quarter();
        test_rgb_align();
        test_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
